knn_local_buf_ctrl: RTL and testbench
=====================================

KNN_LOCAL_BUF_CTRL -- requirements
Module: knn_local_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256, meaning the memory word and stream beat width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11, meaning the memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 2048, meaning the number of memory words.
REQ-004 The block SHALL have parameter RD_LATENCY, default 2, legal range 1..4, meaning the memory cycles from a read issue to valid mem_q0.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, width 1: a one-cycle pulse that begins a fill-then-drain job.
REQ-008 The block SHALL have port num_words, input, width ADDR_WIDTH+1: the job length, sampled when start is accepted.
REQ-009 The block SHALL have ports s_data (input, DATA_WIDTH), s_valid (input, 1) and s_ready (output, 1): the fill stream.
REQ-010 The block SHALL have ports m_data (output, DATA_WIDTH), m_valid (output, 1) and m_ready (input, 1): the drain stream.
REQ-011 The block SHALL have port busy, output, width 1: high whenever the block is not in IDLE.
REQ-012 The block SHALL have port done, output, width 1: a one-cycle pulse at job completion.
REQ-013 The block SHALL have port mem_address0, output, width ADDR_WIDTH: the memory address.
REQ-014 The block SHALL have ports mem_ce0, mem_we0 and mem_d0, outputs of width 1, 1 and DATA_WIDTH: memory enable, write enable and write data.
REQ-015 The block SHALL have port mem_q0, input, width DATA_WIDTH: the memory read data.

Function
REQ-016 The block SHALL implement states IDLE, FILL, DRAIN, FLUSH and DONE.
REQ-017 In IDLE, start=1 SHALL latch len = min(num_words, DEPTH), clear wr_ptr, rd_ptr and beat counters, and move the block to FILL; if len=0 it SHALL move to DONE instead.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 In FILL, s_ready SHALL be 1, and in every other state s_ready SHALL be 0.
REQ-020 In FILL, each s_valid&&s_ready beat SHALL drive, combinationally in the same cycle, mem_ce0=1, mem_we0=1, mem_address0=wr_ptr and mem_d0=s_data; wr_ptr SHALL then increment.
REQ-021 After the beat with wr_ptr=len-1 is written, the block SHALL move to DRAIN on the next cycle.
REQ-022 In DRAIN, a read SHALL be issued (mem_ce0=1, mem_we0=0, mem_address0=rd_ptr) only when rd_ptr<len and credit>0.
   - credit = FIFO free entries minus reads in flight.
REQ-023 Read issue SHALL never be combinationally dependent on m_ready.
REQ-024 A RD_LATENCY-deep valid shift register SHALL track reads in flight; mem_q0 SHALL be captured into the output FIFO exactly RD_LATENCY cycles after its issue.
REQ-025 The output FIFO SHALL have depth RD_LATENCY+2 and SHALL never overflow.
   - A write into the FIFO when it is full is a design error.
REQ-026 m_valid SHALL equal FIFO not-empty, and m_data SHALL be the FIFO head.
   - Data is retained while m_valid=1 and m_ready=0.
REQ-027 With m_ready held at 1, the first m_valid SHALL assert RD_LATENCY+1 cycles after the first read issue, followed by one beat per cycle.
REQ-028 After the last read is issued, the block SHALL move to FLUSH.
REQ-029 In FLUSH, once the out_cnt=len-th beat has been accepted, the block SHALL move to DONE.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-031 Outside FILL and DRAIN read issues, mem_ce0 and mem_we0 SHALL be 0.
REQ-032 Address wrap SHALL NOT occur, because len is at most DEPTH.
REQ-033 num_words greater than DEPTH SHALL be clamped to DEPTH.

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE, empty the FIFO, clear all pointers, counters and in-flight valids, and drive s_ready=0, m_valid=0, busy=0, done=0, mem_ce0=0 and mem_we0=0.
REQ-035 On reset mid-job, in-flight reads SHALL be discarded, no m_valid SHALL appear after the reset is released, and memory contents SHALL not be cleared.
REQ-036 The first start SHALL be accepted on the second rising edge after reset_n deasserts.

Verification
REQ-037 Basic job: start with num_words=4, 4 beats 0xA0..0xA3, m_ready=1 -> writes to addresses 0..3, reads 0..3, m_data sequence 0xA0..0xA3, then one done pulse.
REQ-038 Backpressure: len=16, m_ready toggling 1,0,0 -> all 16 beats delivered in order, no FIFO overflow, no read issued while credit=0.
REQ-039 Empty job: start with num_words=0 -> done pulses within 2 cycles, and mem_ce0 never asserts.
REQ-040 Clamp: num_words=4095 with DEPTH=2048 -> exactly 2048 writes and 2048 reads, with last address 2047.
REQ-041 Mid-drain reset: reset_n=0 at drain beat 5 of 10 -> outputs return to reset values immediately, m_valid stays 0 after release, and a new job then runs correctly.
REQ-042 Latency sweep: RD_LATENCY set to 1 and to 4, with m_ready=1 -> the first m_valid asserts RD_LATENCY+1 cycles after the first read, and data is correct.

Source files
------------

// File: rtl/knn_local_buf_ctrl.sv
// Small synchronous FIFO used as the drain-side landing buffer for memory reads.
// Latency: a written entry is visible at the head on the cycle after the write.
// Backpressure: head is held while rd_rdy=0; the writer must respect count (no full guard).
module knn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;
    logic             do_rd;

    assign rd_vld = (count != '0);
    assign rd_dat = store[rd_idx];
    assign do_rd  = rd_vld && rd_rdy;

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            store[wr_idx] <= wr_dat;
        end
    end

    // Circular pointers and occupancy; DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_idx <= (wr_idx == PW'(DEPTH - 1)) ? '0 : wr_idx + PW'(1);
            end
            if (do_rd) begin
                rd_idx <= (rd_idx == PW'(DEPTH - 1)) ? '0 : rd_idx + PW'(1);
            end
            count <= count + CW'(wr_vld) - CW'(do_rd);
        end
    end
endmodule

// Fill-then-drain controller: streams a job into local memory, then reads it back out.
// Latency: a read issued in cycle t appears on m_data in cycle t+RD_LATENCY+1.
// Backpressure: s_ready only in FILL; reads issue only with FIFO credit, so m_ready never stalls memory.
module knn_local_buf_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
);
    localparam int CW         = ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int FCW        = $clog2(FIFO_DEPTH + 1);
    localparam int IW         = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  armed;
    logic [CW-1:0]         len;
    logic [CW-1:0]         len_in;
    logic [CW-1:0]         len_last;
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         out_cnt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [IW-1:0]         infl_cnt;
    logic [FCW-1:0]        fifo_cnt;
    logic                  job_go;
    logic                  wr_beat;
    logic                  rd_issue;
    logic                  capture;
    logic                  out_beat;
    logic                  has_credit;

    // Clamp so addresses never wrap past the last memory word.
    assign len_in   = (num_words > CW'(DEPTH)) ? CW'(DEPTH) : num_words;
    assign len_last = len - CW'(1);
    // armed delays the first accepted start to the second edge after reset release.
    assign job_go   = (state == IDLE) && start && armed;
    assign capture  = rd_pipe[RD_LATENCY-1];
    assign out_beat = m_valid && m_ready;
    assign busy     = (state != IDLE);
    // Credit counts only registered occupancy, so read issue never looks at m_ready.
    assign has_credit = (int'(fifo_cnt) + int'(infl_cnt)) < FIFO_DEPTH;

    knn_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (capture),
        .wr_dat  (mem_q0),
        .rd_rdy  (m_ready),
        .rd_vld  (m_valid),
        .rd_dat  (m_data),
        .count   (fifo_cnt)
    );

    // Next-state and memory/stream strobes.
    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        done         = 1'b0;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_address0 = '0;
        mem_d0       = '0;
        wr_beat      = 1'b0;
        rd_issue     = 1'b0;
        case (state)
            IDLE: begin
                if (job_go) begin
                    state_nxt = (len_in == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_beat      = 1'b1;
                    mem_ce0      = 1'b1;
                    mem_we0      = 1'b1;
                    mem_address0 = wr_ptr[ADDR_WIDTH-1:0];
                    mem_d0       = s_data;
                    if (wr_ptr == len_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((rd_ptr < len) && has_credit) begin
                    rd_issue     = 1'b1;
                    mem_ce0      = 1'b1;
                    mem_address0 = rd_ptr[ADDR_WIDTH-1:0];
                    if (rd_ptr == len_last) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_beat && (out_cnt == len_last)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job length, write/read pointers and accepted-beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b0;
            len     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_cnt <= '0;
        end else begin
            armed <= 1'b1;
            if (job_go) begin
                len     <= len_in;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                out_cnt <= '0;
            end else begin
                if (wr_beat) begin
                    wr_ptr <= wr_ptr + CW'(1);
                end
                if (rd_issue) begin
                    rd_ptr <= rd_ptr + CW'(1);
                end
                if (out_beat) begin
                    out_cnt <= out_cnt + CW'(1);
                end
            end
        end
    end

    // Reads in flight: the pipe's last stage marks the cycle mem_q0 is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe  <= '0;
            infl_cnt <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            infl_cnt <= infl_cnt + IW'(rd_issue) - IW'(capture);
        end
    end
endmodule

// File: tb/tb_knn_local_buf_ctrl.sv
module tb_knn_local_buf_ctrl;
    localparam int DW  = 256;
    localparam int AW  = 11;
    localparam int DEP = 2048;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset_n;
    logic          start;
    logic          start_sw;
    logic [AW:0]   num_words;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0;
    logic          mem_we0;
    logic [DW-1:0] mem_d0;
    logic [DW-1:0] mem_q0;

    knn_local_buf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .mem_address0(mem_address0),
        .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0)
    );

    // Memory model with RD_LATENCY-cycle read; all-ones marks "no read this cycle".
    logic [DW-1:0] mem  [DEP];
    logic [DW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) mem[mem_address0] <= mem_d0;
        rpipe[0] <= (mem_ce0 && !mem_we0) ? mem[mem_address0] : '1;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_q0 = rpipe[LAT-1];

    // Latency-sweep instances (RD_LATENCY 1 and 4), small memories, m_ready tied high.
    logic          sw1_s_ready, sw1_m_valid, sw1_busy, sw1_done, sw1_ce, sw1_we;
    logic [DW-1:0] sw1_m_data, sw1_d, sw1_q;
    logic [3:0]    sw1_addr;
    logic          sw4_s_ready, sw4_m_valid, sw4_busy, sw4_done, sw4_ce, sw4_we;
    logic [DW-1:0] sw4_m_data, sw4_d, sw4_q;
    logic [3:0]    sw4_addr;

    knn_local_buf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1)
    ) dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(start_sw), .num_words(num_words[4:0]),
        .s_data(s_data), .s_valid(s_valid), .s_ready(sw1_s_ready),
        .m_data(sw1_m_data), .m_valid(sw1_m_valid), .m_ready(1'b1),
        .busy(sw1_busy), .done(sw1_done), .mem_address0(sw1_addr),
        .mem_ce0(sw1_ce), .mem_we0(sw1_we), .mem_d0(sw1_d), .mem_q0(sw1_q)
    );
    knn_local_buf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(4)
    ) dut_l4 (
        .clk(clk), .reset_n(reset_n), .start(start_sw), .num_words(num_words[4:0]),
        .s_data(s_data), .s_valid(s_valid), .s_ready(sw4_s_ready),
        .m_data(sw4_m_data), .m_valid(sw4_m_valid), .m_ready(1'b1),
        .busy(sw4_busy), .done(sw4_done), .mem_address0(sw4_addr),
        .mem_ce0(sw4_ce), .mem_we0(sw4_we), .mem_d0(sw4_d), .mem_q0(sw4_q)
    );

    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] q1_pipe;
    always @(posedge clk) begin
        if (sw1_ce && sw1_we) mem1[sw1_addr] <= sw1_d;
        q1_pipe <= (sw1_ce && !sw1_we) ? mem1[sw1_addr] : '1;
    end
    assign sw1_q = q1_pipe;

    logic [DW-1:0] mem4 [16];
    logic [DW-1:0] q4_pipe [4];
    always @(posedge clk) begin
        if (sw4_ce && sw4_we) mem4[sw4_addr] <= sw4_d;
        q4_pipe[0] <= (sw4_ce && !sw4_we) ? mem4[sw4_addr] : '1;
        for (int i = 1; i < 4; i++) q4_pipe[i] <= q4_pipe[i-1];
    end
    assign sw4_q = q4_pipe[3];

    // Scoreboard state.
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp1 [$];
    logic [DW-1:0] exp4 [$];
    int wr_exp = 0, rd_exp = 0, outst = 0;
    int wr_cnt = 0, rd_cnt = 0, ce_cnt = 0, beat_cnt = 0;
    int last_wr = -1, last_rd = -1;
    int first_rd = -1, first_mv = -1;
    int f1_rd = -1, f1_mv = -1, f4_rd = -1, f4_mv = -1;
    int rdy_mode = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", nm);
    endtask

    // m_ready: constant 1, or the repeating 1,0,0 pattern.
    always @(posedge clk) begin
        #1;
        m_ready = (rdy_mode == 0) || (cyc % 3 == 0);
    end

    // Monitor for the main instance: addresses, credit, output beats against the queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            wr_exp = 0; rd_exp = 0; outst = 0; first_rd = -1; first_mv = -1;
        end else begin
            if (start && !busy) begin
                wr_exp = 0; rd_exp = 0; outst = 0; first_rd = -1; first_mv = -1;
            end
            if (mem_ce0) ce_cnt++;
            if (mem_ce0 && mem_we0) begin
                chk("wr_addr", DW'(mem_address0), DW'(wr_exp));
                wr_exp++; wr_cnt++; last_wr = int'(mem_address0);
            end
            if (mem_ce0 && !mem_we0) begin
                chk("rd_addr", DW'(mem_address0), DW'(rd_exp));
                chk("rd_credit", DW'(outst < LAT + 2), DW'(1));
                if (first_rd < 0) first_rd = cyc;
                outst++; rd_exp++; rd_cnt++; last_rd = int'(mem_address0);
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else chk("m_data", m_data, exp_q.pop_front());
                outst--; beat_cnt++;
            end
        end
    end

    // Monitors for the latency-sweep instances.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sw1_ce && !sw1_we && f1_rd < 0) f1_rd = cyc;
            if (sw1_m_valid) begin
                if (f1_mv < 0) f1_mv = cyc;
                if (exp1.size() == 0) fail_now("l1_unexpected_beat");
                else chk("l1_m_data", sw1_m_data, exp1.pop_front());
            end
            if (sw4_ce && !sw4_we && f4_rd < 0) f4_rd = cyc;
            if (sw4_m_valid) begin
                if (f4_mv < 0) f4_mv = cyc;
                if (exp4.size() == 0) fail_now("l4_unexpected_beat");
                else chk("l4_m_data", sw4_m_data, exp4.pop_front());
            end
        end
    end

    task automatic push_exp(input int len, input int base);
        for (int i = 0; i < len; i++) exp_q.push_back(DW'(base + i));
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        num_words = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int len, input int base, input bit sw);
        bit ok;
        for (int i = 0; i < len; i++) begin
            ok = 1'b0;
            s_data  = DW'(base + i);
            s_valid = 1'b1;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = sw ? (sw1_s_ready && sw4_s_ready) : s_ready;
            end
            if (!ok) begin
                fail_now("feed_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({nm, "_done"}, DW'(seen), DW'(1));
        if (seen) begin
            @(negedge clk);
            chk({nm, "_done_pulse"}, DW'({done, busy}), DW'(0));
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_s_ready"}, DW'(s_ready), '0);
        chk({nm, "_m_valid"}, DW'(m_valid), '0);
        chk({nm, "_busy"},    DW'(busy),    '0);
        chk({nm, "_done"},    DW'(done),    '0);
        chk({nm, "_ce"},      DW'(mem_ce0), '0);
        chk({nm, "_we"},      DW'(mem_we0), '0);
    endtask

    task automatic run_job(input int n, input int len, input int base, input int budget, input string nm);
        int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        push_exp(len, base);
        start_job(n);
        feed(len, base, 1'b0);
        wait_done(budget, nm);
        chk({nm, "_writes"}, DW'(wr_cnt - w0), DW'(len));
        chk({nm, "_reads"},  DW'(rd_cnt - r0), DW'(len));
        chk({nm, "_drained"}, DW'(exp_q.size()), '0);
    endtask

    initial begin
        int w0, r0, c0, b0, bad;
        bit s1, s4;
        reset_n = 1'b0; start = 1'b0; start_sw = 1'b0; num_words = '0;
        s_data = '0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");

        // Basic job; start held across the first edge after release must be ignored there.
        reset_n = 1'b1;
        push_exp(4, 'hA0);
        w0 = wr_cnt; r0 = rd_cnt;
        start = 1'b1; num_words = 12'd4;
        @(posedge clk); #1;
        chk("start_first_edge_ignored", DW'(busy), DW'(0));
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_second_edge", DW'(busy), DW'(1));
        feed(4, 'hA0, 1'b0);
        wait_done(40, "basic");
        chk("basic_writes", DW'(wr_cnt - w0), DW'(4));
        chk("basic_reads",  DW'(rd_cnt - r0), DW'(4));
        chk("basic_latency", DW'(first_mv - first_rd), DW'(LAT + 1));
        chk("basic_drained", DW'(exp_q.size()), '0);

        // Backpressure with 1,0,0 m_ready; a stray start mid-drain must be ignored.
        rdy_mode = 1;
        w0 = wr_cnt; r0 = rd_cnt;
        push_exp(16, 'h100);
        start_job(16);
        feed(16, 'h100, 1'b0);
        start = 1'b1; num_words = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, "bp");
        chk("bp_writes", DW'(wr_cnt - w0), DW'(16));
        chk("bp_reads",  DW'(rd_cnt - r0), DW'(16));
        chk("bp_drained", DW'(exp_q.size()), '0);
        rdy_mode = 0;

        // Empty job: done within 2 cycles, no memory access at all.
        c0 = ce_cnt;
        start_job(0);
        wait_done(2, "empty");
        chk("empty_no_ce", DW'(ce_cnt - c0), '0);

        // Clamp: 4095 requested, 2048 written and read, last address 2047.
        run_job(4095, DEP, 'h2000, 3000, "clamp");
        chk("clamp_last_wr", DW'(last_wr), DW'(DEP - 1));
        chk("clamp_last_rd", DW'(last_rd), DW'(DEP - 1));

        // Reset in the middle of a 10-beat drain, after 5 beats accepted.
        push_exp(10, 'h300);
        b0 = beat_cnt;
        start_job(10);
        feed(10, 'h300, 1'b0);
        for (int t = 0; t < 100 && (beat_cnt - b0) < 5; t++) begin
            @(negedge clk); #2;
        end
        chk("mid_beats_before_rst", DW'(beat_cnt - b0), DW'(5));
        chk("mid_busy_before_rst", DW'(busy), DW'(1));
        reset_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) bad++;
        end
        chk("no_m_valid_after_rst", DW'(bad), '0);
        @(posedge clk); #1;
        run_job(5, 5, 'h600, 60, "post_rst");

        // Latency sweep: RD_LATENCY 1 and 4 side by side.
        for (int i = 0; i < 6; i++) begin
            exp1.push_back(DW'('h700 + i));
            exp4.push_back(DW'('h700 + i));
        end
        f1_rd = -1; f1_mv = -1; f4_rd = -1; f4_mv = -1;
        start_sw = 1'b1; num_words = 12'd6;
        @(posedge clk); #1;
        start_sw = 1'b0;
        feed(6, 'h700, 1'b1);
        s1 = 1'b0; s4 = 1'b0;
        for (int t = 0; t < 100 && !(s1 && s4); t++) begin
            @(negedge clk);
            if (sw1_done) s1 = 1'b1;
            if (sw4_done) s4 = 1'b1;
        end
        chk("l1_done", DW'(s1), DW'(1));
        chk("l4_done", DW'(s4), DW'(1));
        chk("l1_latency", DW'(f1_mv - f1_rd), DW'(2));
        chk("l4_latency", DW'(f4_mv - f4_rd), DW'(5));
        chk("l1_drained", DW'(exp1.size()), '0);
        chk("l4_drained", DW'(exp4.size()), '0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "simulation time limit reached");
    end
endmodule
